vga_pos_scheduler: RTL and testbench
====================================

Name: vga_pos_scheduler

Overview:
- Frame-synchronous position scheduler for the VGA display path.
- Arbitrates position updates from two requesters: req0 is the processor store path, req1 is the animation/input path.
- Buffers the winning update in a shadow register and commits it to the live posX/posY only on a frame-start pulse. The drawn object therefore never changes mid-frame.
- posX/posY drive the VGA top's position inputs; frame_start is driven by the sync controller's end-of-frame refresh pulse.

Parameters:
- W, 10, coordinate width.
- X_MAX, 639, largest legal X; larger requests are clamped to this.
- Y_MAX, 479, largest legal Y; larger requests are clamped to this.
- INIT_X, 320, posX reset value.
- INIT_Y, 240, posY reset value.
- CNT_W, 8, width of the overwrite counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req0  in  1  requester 0 update request (level).
- x0  in  W  requester 0 X.
- y0  in  W  requester 0 Y.
- ack0  out  1  one-cycle accept pulse for requester 0.
- req1  in  1  requester 1 update request (level).
- x1  in  W  requester 1 X.
- y1  in  W  requester 1 Y.
- ack1  out  1  one-cycle accept pulse for requester 1.
- frame_start  in  1  one-cycle pulse, same clk domain, marks the frame boundary.
- posX  out  W  live X position.
- posY  out  W  live Y position.
- pending  out  1  shadow holds an uncommitted update.
- commit  out  1  one-cycle pulse; posX/posY changed this cycle.
- drop_count  out  CNT_W  saturating count of overwritten, never-committed updates.

Behaviour:
- Reset (reset=0 sampled at clk edge):
  - posX=INIT_X, posY=INIT_Y, shadow=INIT.
  - ack0=ack1=0, commit=0, pending=0, drop_count=0.
  - State=IDLE; round-robin pointer prefers req0.
  - Reset mid-HOLD discards the shadow; no commit occurs.
- States:
  - IDLE: shadow empty.
  - HOLD: shadow valid, waiting for frame_start.
  - pending=1 exactly when state is HOLD.
- Arbitration (evaluated every cycle in both states):
  - Only one requester active: it is granted.
  - Both active: grant the one not granted last, then flip the pointer to the other.
  - The pointer only updates when a grant is made.
- Handshake:
  - A grant at edge N captures the clamped x/y into the shadow and raises ackK for cycle N+1 only.
  - A requester holding req high after its ack is granted again, as a new request.
  - Requesters must drop req in the cycle they see ack, otherwise the request is re-granted.
- Clamping:
  - x > X_MAX gives X_MAX; y > Y_MAX gives Y_MAX. Unsigned compare.
  - Clamping is applied before the value enters the shadow.
- Transitions:
  - IDLE, grant: go to HOLD. This applies even if frame_start is high in the same cycle; there is no bypass, so the update commits at the next frame.
  - HOLD, grant, no frame_start: shadow overwritten; drop_count+1, saturating at all-ones; stay in HOLD.
  - HOLD, frame_start, no grant: posX/posY take the shadow at this edge; commit=1 the next cycle; go to IDLE.
  - HOLD, frame_start and grant in the same cycle: the old shadow commits to posX/posY; the new value loads the shadow; stay in HOLD; drop_count unchanged.
  - frame_start in IDLE: no effect.
- Latency:
  - Request to ack: 1 cycle.
  - Request to visible position: the first frame_start strictly after the grant edge.
  - posX/posY change only on commit edges.

Decomposition:
- Package vga_sched_pkg contains:
  - state_t enum {IDLE, HOLD};
  - screen constants H_ACTIVE=640 and V_ACTIVE=480, with default X_MAX/Y_MAX derived from them;
  - a clamp function.
- Sub-module rr_arbiter2: 2-way round-robin arbiter with req[1:0] in and grant[1:0] out (one-hot or zero), plus an internal pointer.

Test Plan:
- Reset:
  - Drive reset=0 for 2 cycles, then release.
  - Expect posX=320, posY=240, pending=0, drop_count=0, acks=0, commit=0.
- Single update:
  - req0 with (100,50); ack0 pulses the next cycle; pending=1; posX stays 320.
  - frame_start pulse: posX=100, posY=50 and commit=1 the cycle after; pending=0.
- Contention:
  - req0 and req1 held together.
  - Grants alternate 0,1,0,1: ack0 and ack1 each pulse on alternate cycles; drop_count increments each overwrite.
  - On frame_start, the value of the last grant commits.
- Clamp:
  - req1 with (1000,700) then frame_start: posX=639, posY=479.
- Simultaneous events:
  - Setup: HOLD with shadow (10,10).
  - req0 (20,20) in the same cycle as frame_start: posX=10 and commit; state stays HOLD with shadow 20.
  - Next frame_start: posX=20.
- Reset mid-operation:
  - Setup: HOLD with (5,5); reset=0 for 1 cycle; then frame_start.
  - Expect posX=320, no commit pulse, drop_count=0.

Source files
------------

// File: rtl/vga_sched_pkg.sv
// Shared types, screen geometry and the coordinate clamp used by the
// frame-synchronous position scheduler.
package vga_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned DEF_X_MAX = H_ACTIVE - 1;
    localparam int unsigned DEF_Y_MAX = V_ACTIVE - 1;

    function automatic int unsigned clamp(input int unsigned v, input int unsigned max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester preferred
// on contention and moves only when a grant is issued.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase

        // After any grant, the other requester wins the next tie.
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vga_pos_scheduler.sv
// Buffers arbitrated position updates in a shadow register and commits
// them to the live position only on frame_start, so an object never moves mid-frame.
module vga_pos_scheduler
    import vga_sched_pkg::*;
#(
    parameter int          W      = 10,
    parameter int unsigned X_MAX  = DEF_X_MAX,
    parameter int unsigned Y_MAX  = DEF_Y_MAX,
    parameter int unsigned INIT_X = 320,
    parameter int unsigned INIT_Y = 240,
    parameter int          CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [W-1:0]     x0,
    input  logic [W-1:0]     y0,
    output logic             ack0,
    input  logic             req1,
    input  logic [W-1:0]     x1,
    input  logic [W-1:0]     y1,
    output logic             ack1,
    input  logic             frame_start,
    output logic [W-1:0]     posX,
    output logic [W-1:0]     posY,
    output logic             pending,
    output logic             commit,
    output logic [CNT_W-1:0] drop_count
);

    state_t           state_q, state_d;
    logic [W-1:0]     pos_x_q, pos_x_d;
    logic [W-1:0]     pos_y_q, pos_y_d;
    logic [W-1:0]     shadow_x_q, shadow_x_d;
    logic [W-1:0]     shadow_y_q, shadow_y_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             commit_q, commit_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [1:0]       grant;
    logic             grant_any;
    logic [W-1:0]     new_x;
    logic [W-1:0]     new_y;
    int unsigned      clamped_x;
    int unsigned      clamped_y;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1, req0}),
        .grant (grant)
    );

    assign grant_any = |grant;

    always_comb begin
        clamped_x = clamp(32'(grant[1] ? x1 : x0), X_MAX);
        clamped_y = clamp(32'(grant[1] ? y1 : y0), Y_MAX);
        new_x     = clamped_x[W-1:0];
        new_y     = clamped_y[W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        ack0_d     = grant[0];
        ack1_d     = grant[1];
        commit_d   = 1'b0;
        drop_d     = drop_q;

        unique case (state_q)
            IDLE: begin
                // A grant coinciding with frame_start still waits a full frame.
                if (grant_any) begin
                    shadow_x_d = new_x;
                    shadow_y_d = new_y;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (frame_start) begin
                    pos_x_d  = shadow_x_q;
                    pos_y_d  = shadow_y_q;
                    commit_d = 1'b1;
                    if (grant_any) begin
                        shadow_x_d = new_x;
                        shadow_y_d = new_y;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (grant_any) begin
                    shadow_x_d = new_x;
                    shadow_y_d = new_y;
                    if (drop_q != '1) begin
                        drop_d = drop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pos_x_q    <= W'(INIT_X);
            pos_y_q    <= W'(INIT_Y);
            shadow_x_q <= W'(INIT_X);
            shadow_y_q <= W'(INIT_Y);
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            commit_q   <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            commit_q   <= commit_d;
            drop_q     <= drop_d;
        end
    end

    assign posX       = pos_x_q;
    assign posY       = pos_y_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign commit     = commit_q;
    assign pending    = (state_q == HOLD);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_vga_pos_scheduler.sv
// Directed-vector bench for vga_pos_scheduler with hand-computed expectations.
module tb_vga_pos_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [9:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic       frame_start = 1'b0;
    logic       ack0, ack1, pending, commit;
    logic [9:0] posX, posY;
    logic [7:0] drop_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_pos_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .x0          (x0),
        .y0          (y0),
        .ack0        (ack0),
        .req1        (req1),
        .x1          (x1),
        .y1          (y1),
        .ack1        (ack1),
        .frame_start (frame_start),
        .posX        (posX),
        .posY        (posY),
        .pending     (pending),
        .commit      (commit),
        .drop_count  (drop_count)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        check_val("rst_posX", posX, 320);
        check_val("rst_posY", posY, 240);
        check_val("rst_pending", pending, 0);
        check_val("rst_drop", drop_count, 0);
        check_val("rst_ack0", ack0, 0);
        check_val("rst_ack1", ack1, 0);
        check_val("rst_commit", commit, 0);
        reset = 1'b1;

        // Single update from requester 0
        req0 = 1'b1; x0 = 10'd100; y0 = 10'd50;
        tick();
        req0 = 1'b0;
        check_val("single_ack0", ack0, 1);
        check_val("single_ack1", ack1, 0);
        check_val("single_pending", pending, 1);
        check_val("single_posX_held", posX, 320);
        tick();
        check_val("single_ack0_drop", ack0, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("single_commit", commit, 1);
        check_val("single_posX", posX, 100);
        check_val("single_posY", posY, 50);
        check_val("single_pending_clr", pending, 0);
        tick();
        check_val("single_commit_pulse", commit, 0);

        // Clamp via requester 1
        req1 = 1'b1; x1 = 10'd1000; y1 = 10'd700;
        tick();
        req1 = 1'b0;
        check_val("clamp_ack1", ack1, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("clamp_posX", posX, 639);
        check_val("clamp_posY", posY, 479);
        check_val("clamp_commit", commit, 1);

        // Contention: pointer now prefers req0, so grants go 0,1,0,1
        req0 = 1'b1; x0 = 10'd11; y0 = 10'd12;
        req1 = 1'b1; x1 = 10'd21; y1 = 10'd22;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("cont%0d_ack0", i), ack0, (i % 2 == 0) ? 1 : 0);
            check_val($sformatf("cont%0d_ack1", i), ack1, (i % 2 == 1) ? 1 : 0);
            check_val($sformatf("cont%0d_drop", i), drop_count, i);
        end
        req0 = 1'b0; req1 = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("cont_posX", posX, 21);
        check_val("cont_posY", posY, 22);
        check_val("cont_commit", commit, 1);
        check_val("cont_drop_final", drop_count, 3);

        // Grant in IDLE together with frame_start: no bypass
        req0 = 1'b1; x0 = 10'd7; y0 = 10'd7; frame_start = 1'b1;
        tick();
        req0 = 1'b0; frame_start = 1'b0;
        check_val("nobypass_pending", pending, 1);
        check_val("nobypass_commit", commit, 0);
        check_val("nobypass_posX", posX, 21);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("nobypass_late_posX", posX, 7);

        // Simultaneous grant and frame_start while holding
        req1 = 1'b1; x1 = 10'd10; y1 = 10'd10;
        tick();
        req1 = 1'b0;
        check_val("sim_setup_pending", pending, 1);
        req0 = 1'b1; x0 = 10'd20; y0 = 10'd20; frame_start = 1'b1;
        tick();
        req0 = 1'b0; frame_start = 1'b0;
        check_val("sim_posX", posX, 10);
        check_val("sim_commit", commit, 1);
        check_val("sim_pending", pending, 1);
        check_val("sim_ack0", ack0, 1);
        check_val("sim_drop", drop_count, 3);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("sim_next_posX", posX, 20);
        check_val("sim_next_pending", pending, 0);

        // Reset while holding discards the shadow
        req1 = 1'b1; x1 = 10'd5; y1 = 10'd5;
        tick();
        req1 = 1'b0;
        check_val("rmid_pending", pending, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_val("rmid_pending_clr", pending, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("rmid_commit", commit, 0);
        check_val("rmid_posX", posX, 320);
        check_val("rmid_posY", posY, 240);
        check_val("rmid_drop", drop_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
